// File: rtl/sensor_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : sensor_pkg
//  Description : Shared constants and FSM state encoding for the SPI sensor
//                responder (frame geometry, synchronizer depth, states).
//  Revision    : 1.0 - initial release
// ============================================================================
package sensor_pkg;

    // SCLK cycles in one SPI frame
    localparam int c_FRAME_BITS  = 16;
    // Zero bits transmitted ahead of the sample byte
    localparam int c_LEAD_ZEROS  = 3;
    // Flip-flop depth of each asynchronous input synchronizer
    localparam int c_SYNC_STAGES = 2;
    // Width of the reported sample
    localparam int c_SAMPLE_BITS = 8;

    // Responder frame state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

endpackage : sensor_pkg
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge
//  Description : Multi-stage synchronizer for an asynchronous input with
//                single-cycle rise/fall pulses derived from the synchronized
//                level. The reset value presets the whole chain so that no
//                spurious edge appears when reset is released.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              w_level;

    // Shift the raw input through the synchronizer and keep the previous level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync[0] <= i_async;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_level;
        end
    end

    assign w_level = r_sync[STAGES-1];
    assign o_rise  = w_level & ~r_prev;
    assign o_fall  = ~w_level & r_prev;

endmodule : sync_edge
`default_nettype wire

// File: rtl/sensor_responder.sv
`default_nettype none
// ============================================================================
//  Module      : sensor_responder
//  Description : SPI mode-0 responder oversampled by the system clock. On a
//                chip-select falling edge it latches the sample byte into a
//                framed transmit word, shifts MISO out on SCLK falling edges,
//                collects MOSI on SCLK rising edges and reports the received
//                word with a one-cycle done pulse (or an abort pulse when the
//                initiator releases chip select early).
//  Revision    : 1.0 - initial release
// ============================================================================
module sensor_responder
    import sensor_pkg::*;
#(
    parameter int FRAME_BITS  = c_FRAME_BITS,
    parameter int LEAD_ZEROS  = c_LEAD_ZEROS,
    parameter int SYNC_STAGES = c_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SS,
    input  logic                  SCLK,
    input  logic                  MOSI,
    output logic                  MISO,
    input  logic [7:0]            sample,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  frame_done,
    output logic                  frame_abort,
    output logic                  busy
);

    // Counter reaches FRAME_BITS on the last edge, so it needs one extra code
    localparam int c_CNT_W      = $clog2(FRAME_BITS + 1);
    localparam int c_TAIL_ZEROS = FRAME_BITS - LEAD_ZEROS - c_SAMPLE_BITS;
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(FRAME_BITS - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_ss_rise;
    logic                  w_ss_fall;
    logic                  w_sclk_rise;
    logic                  w_sclk_fall;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                  w_mosi;

    logic                  w_start;
    logic                  w_shift_in;
    logic                  w_shift_out;
    logic                  w_done;
    logic                  w_abort;

    logic [FRAME_BITS-1:0] w_tx_load;
    logic [FRAME_BITS-1:0] w_rx_next;
    logic [FRAME_BITS-1:0] r_tx;
    logic [FRAME_BITS-1:0] r_rx;
    logic [FRAME_BITS-1:0] r_rx_data;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic                  r_miso;
    logic                  r_done;
    logic                  r_abort;

    // Chip select idles high: preset its chain so reset release is not an edge
    sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_ss_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (SS),
        .o_rise  (w_ss_rise),
        .o_fall  (w_ss_fall)
    );

    // SCLK idles low
    sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sclk_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (SCLK),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    // MOSI only needs a level, with the same latency as the SCLK edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync[0] <= MOSI;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_mosi_sync[i] <= r_mosi_sync[i-1];
            end
        end
    end

    assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
    assign w_tx_load = FRAME_BITS'(sample) << c_TAIL_ZEROS;
    assign w_rx_next = {r_rx[FRAME_BITS-2:0], w_mosi};

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath strobes; chip-select edges win over SCLK edges
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_shift_in   = 1'b0;
        w_shift_out  = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ss_fall) begin
                    w_start      = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_ss_rise) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_sclk_rise) begin
                    w_shift_in = 1'b1;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_done       = 1'b1;
                        w_state_next = ST_HOLD;
                    end
                end else if (w_sclk_fall) begin
                    w_shift_out = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_ss_rise) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Shift registers, bit counter and the completed-word register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx      <= '0;
            r_rx      <= '0;
            r_bit_cnt <= '0;
            r_rx_data <= '0;
        end else begin
            if (w_start) begin
                r_tx      <= w_tx_load;
                r_rx      <= '0;
                r_bit_cnt <= '0;
            end
            if (w_shift_in) begin
                r_rx      <= w_rx_next;
                r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
            end
            if (w_shift_out) begin
                r_tx <= r_tx << 1;
            end
            if (w_done) begin
                r_rx_data <= w_rx_next;
            end
        end
    end

    // MISO: first bit on frame start, next bit after each SCLK fall, else 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_miso <= 1'b0;
        end else if (w_start) begin
            r_miso <= w_tx_load[FRAME_BITS-1];
        end else if (w_shift_out) begin
            r_miso <= r_tx[FRAME_BITS-2];
        end else if (w_state_next != ST_SHIFT) begin
            r_miso <= 1'b0;
        end
    end

    // Registered single-cycle status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_done  <= w_done;
            r_abort <= w_abort;
        end
    end

    assign MISO        = r_miso;
    assign rx_data     = r_rx_data;
    assign frame_done  = r_done;
    assign frame_abort = r_abort;
    assign busy        = (r_state == ST_SHIFT);

endmodule : sensor_responder
`default_nettype wire

// File: tb/tb_sensor_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sensor_responder
//  Description : Directed bench for sensor_responder acting as the SPI
//                initiator at clk/10, with a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sensor_responder;

    localparam int FB = 16;
    localparam int LZ = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        SS = 1'b1;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic [7:0]  sample = 8'h00;
    logic        MISO;
    logic [15:0] rx_data;
    logic        frame_done;
    logic        frame_abort;
    logic        busy;

    int checks    = 0;
    int failures  = 0;
    int obs_done  = 0;
    int obs_abort = 0;
    int exp_done  = 0;
    int exp_abort = 0;

    // Model: word the initiator is sending now, and last completed word
    logic [15:0] m_word = 16'h0000;
    logic [15:0] m_last = 16'h0000;
    logic [31:0] cap;

    sensor_responder #(
        .FRAME_BITS  (FB),
        .LEAD_ZEROS  (LZ),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .SS          (SS),
        .SCLK        (SCLK),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .sample      (sample),
        .rx_data     (rx_data),
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Word the initiator must see: LZ zeros, the byte, then zero padding
    function automatic logic [15:0] exp_tx(input logic [7:0] s);
        logic [15:0] w;
        w = {8'h00, s};
        return w << (FB - LZ - 8);
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One initiator transaction; SCLK half period is 5 clk
    task automatic run_frame(input logic [7:0] smp, input logic [7:0] smp_late,
                             input int change_at, input logic [15:0] mosi_w,
                             input int n_sclk, input bit sclk_high_start,
                             output logic [31:0] captured);
        captured = 32'h0;
        sample   = smp;
        m_word   = mosi_w;
        if (n_sclk >= FB) exp_done++;
        else              exp_abort++;
        if (sclk_high_start) begin
            SCLK = 1'b1;
            wait_clk(8);
        end
        SS   = 1'b0;
        SCLK = 1'b0;
        for (int i = 0; i < n_sclk; i++) begin
            MOSI = (i < FB) ? mosi_w[FB-1-i] : 1'b0;
            wait_clk(5);
            if (i == 0) chk("busy_in_frame", 32'(busy), 32'h1);
            captured = {captured[30:0], MISO};
            SCLK = 1'b1;
            if (i == change_at) sample = smp_late;
            wait_clk(5);
            SCLK = 1'b0;
        end
        wait_clk(5);
        SS = 1'b1;
        wait_clk(8);
        if (n_sclk >= FB) m_last = mosi_w;
        chk("busy_after_frame", 32'(busy), 32'h0);
    endtask

    // Per-cycle comparison against the frame-level model
    always @(negedge clk) begin
        if (frame_done)  obs_done++;
        if (frame_abort) obs_abort++;
        if (!busy)       chk("miso_zero_when_not_busy", 32'(MISO), 32'h0);
        if (frame_done)  chk("rx_data_at_done", 32'(rx_data), 32'(m_word));
        if (frame_abort) chk("rx_data_at_abort", 32'(rx_data), 32'(m_last));
        if (frame_done && frame_abort) chk("done_abort_exclusive", 32'h1, 32'h0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        wait_clk(3);
        chk("reset_rx_data",     32'(rx_data),     32'h0);
        chk("reset_busy",        32'(busy),        32'h0);
        chk("reset_miso",        32'(MISO),        32'h0);
        chk("reset_frame_done",  32'(frame_done),  32'h0);
        chk("reset_frame_abort", 32'(frame_abort), 32'h0);
        rst = 1'b0;
        wait_clk(5);

        // Full frame: A5 out, C3F0 in
        run_frame(8'hA5, 8'hA5, -1, 16'hC3F0, 16, 1'b0, cap);
        chk("a5_miso_word", 32'(cap[15:0]), 32'h14A0);
        chk("a5_rx_data",   32'(rx_data),   32'hC3F0);
        chk("a5_done_cnt",  32'(obs_done),  32'd1);

        // Abort after 9 SCLKs
        run_frame(8'h5A, 8'h5A, -1, 16'h1234, 9, 1'b0, cap);
        chk("abort_cnt",      32'(obs_abort), 32'd1);
        chk("abort_no_done",  32'(obs_done),  32'd1);
        chk("abort_rx_keep",  32'(rx_data),   32'hC3F0);
        chk("abort_miso",     32'(MISO),      32'h0);

        // Sample change mid-frame must not leak into the current frame
        run_frame(8'h11, 8'hFF, 4, 16'h0F0F, 16, 1'b0, cap);
        chk("s11_miso_literal", 32'(cap[15:0]), 32'h0220);
        chk("s11_miso_model",   32'(cap[15:0]), 32'(exp_tx(8'h11)));
        run_frame(8'hFF, 8'hFF, -1, 16'hA55A, 16, 1'b0, cap);
        chk("sff_miso_model", 32'(cap[15:0]), 32'(exp_tx(8'hFF)));
        chk("sff_rx_data",    32'(rx_data),   32'hA55A);

        // Reset in the middle of a frame
        sample = 8'h33;
        SS = 1'b0;
        for (int i = 0; i < 5; i++) begin
            MOSI = i[0];
            wait_clk(5);
            SCLK = 1'b1;
            wait_clk(5);
            SCLK = 1'b0;
        end
        wait_clk(2);
        rst = 1'b1;
        wait_clk(2);
        chk("midrst_busy",    32'(busy),    32'h0);
        chk("midrst_rx_data", 32'(rx_data), 32'h0);
        SS = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        m_last = 16'h0000;
        wait_clk(8);
        chk("midrst_done_cnt",  32'(obs_done),  32'(exp_done));
        chk("midrst_abort_cnt", 32'(obs_abort), 32'(exp_abort));
        run_frame(8'h7E, 8'h7E, -1, 16'h8001, 16, 1'b0, cap);
        chk("s7e_miso_word", 32'(cap[15:0]), 32'h0FC0);
        chk("s7e_rx_data",   32'(rx_data),   32'h8001);

        // 20 SCLKs in one window: extra edges land in HOLD
        run_frame(8'h01, 8'h01, -1, 16'h6C6C, 20, 1'b0, cap);
        chk("s01_miso_word",  32'(cap[19:4]), 32'(exp_tx(8'h01)));
        chk("s01_miso_hold",  32'(cap[3:0]),  32'h0);
        chk("s01_rx_data",    32'(rx_data),   32'h6C6C);
        chk("s01_done_cnt",   32'(obs_done),  32'(exp_done));

        // SS fall coinciding with an SCLK fall: the SCLK edge is dropped
        run_frame(8'h3C, 8'h3C, -1, 16'h5555, 16, 1'b1, cap);
        chk("s3c_miso_word", 32'(cap[15:0]), 32'(exp_tx(8'h3C)));
        chk("s3c_rx_data",   32'(rx_data),   32'h5555);

        chk("final_done_cnt",  32'(obs_done),  32'(exp_done));
        chk("final_abort_cnt", 32'(obs_abort), 32'(exp_abort));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sensor_responder
`default_nettype wire
